seven_segment_scanner: RTL

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

---
 rtl/seven_segment_scanner.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment display scanner.
// Cycles a one-hot digit select across DIGITS positions, holding each for
// REFRESH_DIV clocks, and drives the segment pattern for the selected digit
// through one shared BCD decoder. New values are written into a shadow register.
// They reach the display register only at a frame boundary, so a frame is never
// shown half old and half new.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank zero digits above the
// most significant nonzero digit; digit 0 is always shown).
module seven_segment_scanner #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_enable,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int unsigned SlotW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SlotW-1:0] SlotLast = SlotW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(DIGITS - 1);

  logic [SlotW-1:0]      slot_q, slot_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [4*DIGITS-1:0]   display_q, display_d;
  logic                  pending_q, pending_d;
  logic                  frame_done_q, frame_done_d;
  logic [6:0]            segments_q, segments_d;
  logic [DIGITS-1:0]     digit_enable_q, digit_enable_d;

  logic                  slot_tc;
  logic                  frame_end;
  logic [3:0]            cur_code;
  logic                  cur_lz_blank;

  // Codes 10-15 have no glyph and render dark.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  // Scan timing: slot counter, digit index and frame boundary detection.
  always_comb begin
    slot_tc   = (slot_q == SlotLast);
    frame_end = slot_tc && (idx_q == IdxLast);
    slot_d    = slot_tc ? '0 : slot_q + SlotW'(1);
    idx_d     = idx_q;
    if (slot_tc) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    end
  end

  // Shadow/display handoff: a load at the boundary bypasses the shadow.
  always_comb begin
    shadow_d     = shadow_q;
    display_d    = display_q;
    pending_d    = pending_q;
    frame_done_d = frame_end;
    if (frame_end) begin
      if (load) begin
        display_d = value;
      end else if (pending_q) begin
        display_d = shadow_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end
  end

  // Select the current digit's code from the display register.
  always_comb begin
    cur_code = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_code = display_q[4*i +: 4];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz_mask;

  // lz_mask[i] is set when digit i and every digit above it are zero.
  always_comb begin
    logic all_zero;
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      all_zero   = all_zero && (display_q[4*i +: 4] == 4'd0);
      lz_mask[i] = all_zero;
    end
  end

  // Look up the blank flag for the digit currently being scanned.
  always_comb begin
    cur_lz_blank = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_lz_blank = lz_mask[i];
      end
    end
  end
`else
  // All digits are shown, leading zeros included.
  always_comb begin
    cur_lz_blank = 1'b0;
  end
`endif

  // Output next-state: decoded segments and one-hot enable (blank gates enable only).
  always_comb begin
    segments_d     = cur_lz_blank ? 7'b0000000 : bcd_to_seg(cur_code);
    digit_enable_d = '0;
    if (!blank) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (idx_q == IdxW'(i)) begin
          digit_enable_d[i] = 1'b1;
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_q         <= '0;
      idx_q          <= '0;
      shadow_q       <= '0;
      display_q      <= '0;
      pending_q      <= 1'b0;
      frame_done_q   <= 1'b0;
      segments_q     <= '0;
      digit_enable_q <= '0;
    end else begin
      slot_q         <= slot_d;
      idx_q          <= idx_d;
      shadow_q       <= shadow_d;
      display_q      <= display_d;
      pending_q      <= pending_d;
      frame_done_q   <= frame_done_d;
      segments_q     <= segments_d;
      digit_enable_q <= digit_enable_d;
    end
  end

  assign segments     = segments_q;
  assign digit_enable = digit_enable_q;
  assign pending      = pending_q;
  assign frame_done   = frame_done_q;

endmodule
